// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and break handling.
//
// Ports:
//   clkin       - single clock, all state updates on its rising edge
//   resetn_in   - synchronous active-low reset
//   rx          - asynchronous serial input, idle high, LSB first
//   data_out    - last correctly framed byte, held until the next data_valid
//   data_valid  - one-cycle pulse, data_out was just updated
//   frame_err   - one-cycle pulse, stop bit was sampled low
//   busy        - high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clkin,
    input  logic       resetn_in,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [7:0]       data_out_next;
    logic             data_valid_next;
    logic             frame_err_next;
    logic             busy_next;
    logic             rx_meta;
    logic             rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clkin) begin
        if (!resetn_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and output registers.
    always_ff @(posedge clkin) begin
        if (!resetn_in) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            data_out   <= data_out_next;
            data_valid <= data_valid_next;
            frame_err  <= frame_err_next;
            busy       <= busy_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt + CNT_W'(1);
        bit_idx_next    = bit_idx;
        shift_next      = shift;
        data_out_next   = data_out;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                // Counter held at zero so START always begins at a known phase.
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end

            ST_START: begin
                // Re-check the line half a bit in; a high level is a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_out_next   = shift;
                        data_valid_next = 1'b1;
                        state_next      = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Wait out a held-low line so it cannot start new frames.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// A monitor logs every data_valid / frame_err pulse with its cycle number;
// each test task drives serial frames and compares the logged pulses and
// outputs with what the framing rules predict.
module tb_uart_rx;

    localparam int unsigned BIT = 16;

    logic       clkin     = 1'b0;
    logic       resetn_in = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process.
    int unsigned cyc = 0;
    logic [7:0]  dv_data_q[$];
    int unsigned dv_cyc_q[$];
    int unsigned fe_cyc_q[$];
    int unsigned last_busy_rise = 0;
    logic        busy_prev = 1'b0;
    logic        both_seen = 1'b0;

    // Reference: the last byte received with a good stop bit.
    logic [7:0] exp_data = 8'h00;

    always #5 clkin = ~clkin;

    uart_rx #(.CLKS_PER_BIT(BIT)) dut (
        .clkin      (clkin),
        .resetn_in  (resetn_in),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always @(negedge clkin) begin
        cyc = cyc + 1;
        if (data_valid) begin
            dv_data_q.push_back(data_out);
            dv_cyc_q.push_back(cyc);
        end
        if (frame_err) fe_cyc_q.push_back(cyc);
        if (data_valid && frame_err) both_seen = 1'b1;
        if (busy && !busy_prev) last_busy_rise = cyc;
        busy_prev = busy;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clkin);
    endtask

    // Start bit, 8 data bits LSB first, one stop bit of the given level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clkin);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clkin);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clkin);
    endtask

    task automatic test_reset;
        resetn_in = 1'b0;
        repeat (3) @(negedge clkin);
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        checks++;
        if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: dv=%b fe=%b want 0 0", data_valid, frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        resetn_in = 1'b1;
        @(negedge clkin);
        checks++;
        if (data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL release_first_cycle: dv=%b fe=%b busy=%b want 0 0 0",
                               data_valid, frame_err, busy);
        end
        idle(20);
        checks++;
        if (dv_data_q.size() != 0 || fe_cyc_q.size() != 0) begin
            errors++; $display("FAIL idle_after_reset: dv=%0d fe=%0d want 0 0",
                               dv_data_q.size(), fe_cyc_q.size());
        end
    endtask

    task automatic test_a5;
        int n0 = dv_data_q.size();
        int f0 = fe_cyc_q.size();
        send_frame(8'hA5, 1'b1);
        idle(4);
        exp_data = 8'hA5;
        checks++;
        if (dv_data_q.size() != n0 + 1) begin
            errors++; $display("FAIL a5_dv_count: got %0d want %0d", dv_data_q.size() - n0, 1);
        end else begin
            checks++;
            if (dv_data_q[n0] !== 8'hA5) begin
                errors++; $display("FAIL a5_data_at_pulse: got %h want a5", dv_data_q[n0]);
            end
        end
        checks++;
        if (data_out !== exp_data) begin
            errors++; $display("FAIL a5_data_out: got %h want %h", data_out, exp_data);
        end
        checks++;
        if (fe_cyc_q.size() != f0) begin
            errors++; $display("FAIL a5_frame_err: got %0d pulses want 0", fe_cyc_q.size() - f0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL a5_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_glitch;
        int n0 = dv_data_q.size();
        int f0 = fe_cyc_q.size();
        rx = 1'b0;
        repeat (4) @(negedge clkin);
        idle(40);
        checks++;
        if (dv_data_q.size() != n0 || fe_cyc_q.size() != f0) begin
            errors++; $display("FAIL glitch_pulses: dv=%0d fe=%0d want 0 0",
                               dv_data_q.size() - n0, fe_cyc_q.size() - f0);
        end
        checks++;
        if (data_out !== exp_data) begin
            errors++; $display("FAIL glitch_data_out: got %h want %h", data_out, exp_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_frame_error;
        int n0;
        int f0;
        send_frame(8'hA5, 1'b1);
        idle(2);
        exp_data = 8'hA5;
        n0 = dv_data_q.size();
        f0 = fe_cyc_q.size();
        send_frame(8'h3C, 1'b0);
        repeat (3 * BIT) @(negedge clkin);
        checks++;
        if (fe_cyc_q.size() != f0 + 1) begin
            errors++; $display("FAIL ferr_count: got %0d want 1", fe_cyc_q.size() - f0);
        end
        checks++;
        if (dv_data_q.size() != n0) begin
            errors++; $display("FAIL ferr_no_dv: got %0d want 0", dv_data_q.size() - n0);
        end
        checks++;
        if (data_out !== 8'hA5) begin
            errors++; $display("FAIL ferr_data_held: got %h want a5", data_out);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ferr_busy_in_break: got %b want 1", busy);
        end
        idle(8);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ferr_busy_released: got %b want 0", busy);
        end
        idle(40);
        checks++;
        if (fe_cyc_q.size() != f0 + 1 || dv_data_q.size() != n0) begin
            errors++; $display("FAIL ferr_no_more_pulses: fe=%0d dv=%0d want 1 0",
                               fe_cyc_q.size() - f0, dv_data_q.size() - n0);
        end
    endtask

    task automatic test_back_to_back;
        int n0 = dv_data_q.size();
        int gap;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        exp_data = 8'hFF;
        checks++;
        if (dv_data_q.size() != n0 + 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", dv_data_q.size() - n0);
        end else begin
            checks++;
            if (dv_data_q[n0] !== 8'h00 || dv_data_q[n0+1] !== 8'hFF) begin
                errors++; $display("FAIL b2b_data: got %h %h want 00 ff",
                                   dv_data_q[n0], dv_data_q[n0+1]);
            end
            gap = int'(dv_cyc_q[n0+1] - dv_cyc_q[n0]);
            checks++;
            if (gap < 159 || gap > 161) begin
                errors++; $display("FAIL b2b_spacing: got %0d want 160 +/-1", gap);
            end
        end
    endtask

    task automatic test_reset_abort;
        int n0 = dv_data_q.size();
        int f0 = fe_cyc_q.size();
        logic [7:0] v = 8'h55;
        rx = 1'b0;
        repeat (BIT) @(negedge clkin);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat (BIT) @(negedge clkin);
        end
        rx = v[4];
        repeat (BIT / 2) @(negedge clkin);
        resetn_in = 1'b0;
        @(negedge clkin);
        resetn_in = 1'b1;
        exp_data = 8'h00;
        checks++;
        if (busy !== 1'b0 || data_out !== 8'h00) begin
            errors++; $display("FAIL abort_reset_state: busy=%b data=%h want 0 00", busy, data_out);
        end
        idle(2 * BIT);
        checks++;
        if (dv_data_q.size() != n0 || fe_cyc_q.size() != f0) begin
            errors++; $display("FAIL abort_no_pulse: dv=%0d fe=%0d want 0 0",
                               dv_data_q.size() - n0, fe_cyc_q.size() - f0);
        end
        send_frame(8'h81, 1'b1);
        idle(4);
        exp_data = 8'h81;
        checks++;
        if (dv_data_q.size() != n0 + 1 || data_out !== 8'h81) begin
            errors++; $display("FAIL abort_resume: dv=%0d data=%h want 1 81",
                               dv_data_q.size() - n0, data_out);
        end
    endtask

    task automatic test_stop_timing;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b = 8'($urandom);
            int n0 = dv_data_q.size();
            int lat;
            send_frame(b, 1'b1);
            idle(3);
            exp_data = b;
            checks++;
            if (dv_data_q.size() != n0 + 1) begin
                errors++; $display("FAIL timing_dv_count: got %0d want 1", dv_data_q.size() - n0);
            end else begin
                // busy rises in the cycle after IDLE->START; data_valid rises in the
                // cycle after the stop sample, so the difference is the sample offset.
                lat = int'(dv_cyc_q[n0] - last_busy_rise);
                checks++;
                if (lat < 151 || lat > 153) begin
                    errors++; $display("FAIL timing_stop_sample: got %0d want 152 +/-1", lat);
                end
            end
        end
    endtask

    task automatic test_random_frames;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b = 8'($urandom);
            logic stop_bit = ($urandom_range(0, 3) != 0);
            int n0 = dv_data_q.size();
            int f0 = fe_cyc_q.size();
            int exp_dv = stop_bit ? 1 : 0;
            int exp_fe = stop_bit ? 0 : 1;
            send_frame(b, stop_bit);
            if (stop_bit) begin
                exp_data = b;
                idle(int'($urandom_range(1, 20)));
            end else begin
                idle(2 * BIT);
            end
            checks++;
            if (dv_data_q.size() - n0 != exp_dv || fe_cyc_q.size() - f0 != exp_fe) begin
                errors++; $display("FAIL rand_pulses[%0d]: dv=%0d fe=%0d want %0d %0d", k,
                                   dv_data_q.size() - n0, fe_cyc_q.size() - f0, exp_dv, exp_fe);
            end
            checks++;
            if (data_out !== exp_data) begin
                errors++; $display("FAIL rand_data_out[%0d]: got %h want %h", k, data_out, exp_data);
            end
        end
    endtask

    initial begin
        @(negedge clkin);
        test_reset();
        test_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_abort();
        test_stop_timing();
        test_random_frames();
        checks++;
        if (both_seen !== 1'b0) begin
            errors++; $display("FAIL dv_fe_overlap: got %b want 0", both_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 CLKS_PER_BIT, default 16: clkin cycles per serial bit; SHALL be an even integer >= 4.
Ports:
REQ-002 clkin  input  1: the single clock; all state SHALL update on its rising edge.
REQ-003 resetn_in  input  1: reset, synchronous and active-low.
REQ-004 rx  input  1: serial line, asynchronous to clkin, idle high, 8N1 framing, LSB first.
REQ-005 data_out  output  8: last correctly framed received byte.
REQ-006 data_valid  output  1: one-cycle pulse, data_out just updated.
REQ-007 frame_err  output  1: one-cycle pulse, stop bit sampled low.
REQ-008 busy  output  1: high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_s); only rx_s SHALL be used by the FSM.
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus a bit-time counter (0..CLKS_PER_BIT-1) and a 3-bit bit index.
REQ-011 IDLE: when rx_s==0, go to START with counter cleared.
REQ-012 START: at counter==CLKS_PER_BIT/2-1, sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no outputs pulse).
REQ-013 DATA: at counter==CLKS_PER_BIT-1, shift rx_s into the shift register LSB first and clear the counter; after bit index 7 is sampled, go to STOP.
REQ-014 STOP: at counter==CLKS_PER_BIT-1, sample rx_s; 1 -> load data_out from the shift register, pulse data_valid, go to IDLE; 0 -> pulse frame_err, leave data_out unchanged, go to BREAK.
REQ-015 BREAK: stay until rx_s==1, then go to IDLE; this prevents a held-low line from producing repeated frames.
REQ-016 All samples SHALL occur at bit mid-points: the stop-bit sample is 9.5 bit times after the IDLE->START transition, +/-1 cycle.
REQ-017 data_valid and frame_err SHALL be registered, SHALL assert in the cycle after the stop sample, SHALL last exactly one cycle, and SHALL never be high together.
REQ-018 rx_s is not monitored during DATA; a mid-frame line change only affects sampled bits.
REQ-019 A new start bit SHALL be detectable in the first IDLE cycle after a valid stop, so back-to-back frames with a single stop bit are received without loss.
REQ-020 data_out SHALL hold its value until the next data_valid.

Reset
REQ-021 With resetn_in==0 at a clkin edge: FSM -> IDLE; counter, bit index and shift register -> 0; data_out = 8'h00; data_valid = frame_err = 0; busy = 0; both synchronizer flops = 1 (idle).
REQ-022 A reset asserted mid-frame SHALL abort the frame with no data_valid or frame_err; after release, reception SHALL resume from the next falling edge on rx.
REQ-023 No output SHALL pulse in the first cycle after reset release.

Verification (CLKS_PER_BIT=16)
REQ-024 Send 0xA5 with a valid stop -> exactly one data_valid pulse, data_out=8'hA5, frame_err never high, busy low after the pulse.
REQ-025 rx low for 4 cycles then high -> FSM returns to IDLE, no data_valid or frame_err, data_out unchanged.
REQ-026 After 0xA5, send 0x3C with stop bit 0, then hold rx low for 3 bit times -> one frame_err pulse, data_out stays 8'hA5, busy high until rx returns high, no further pulses.
REQ-027 Back-to-back 0x00 then 0xFF with one stop bit each -> two data_valid pulses 160 +/-1 cycles apart, data_out 8'h00 then 8'hFF.
REQ-028 Assert resetn_in low for 1 cycle during bit 4 of 0x55, then send 0x81 -> no pulse for the aborted frame, one data_valid with data_out=8'h81.
REQ-029 Check that the stop sample falls 152 +/-1 cycles after the IDLE->START transition (REQ-016), and that data_valid asserts in the cycle after it.
